regs_file: RTL and testbench
============================

Name: regs_file

Overview:
- 32-entry x 64-bit general-purpose register file for the 5-stage PowerPC-subset pipeline.
- Two synchronous read ports: decode presents addresses, execute consumes the data one cycle later. Two synchronous write ports are driven from writeback.
- Write-to-read forwarding within the pipeline is done outside this block; the file itself does not bypass.

Parameters:
DATA_W, 64, register width (bit 0 = MSB, [0:DATA_W-1] ordering)
ADDR_W, 5, register index width
NREGS, 32, number of registers (2**ADDR_W)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
rd_en0  input  1  read port 0 enable
rd_addr0  input  ADDR_W  read port 0 index
rd_data0  output  DATA_W  read port 0 data, registered
rd_en1  input  1  read port 1 enable
rd_addr1  input  ADDR_W  read port 1 index
rd_data1  output  DATA_W  read port 1 data, registered
wr_en0  input  1  write port 0 enable
wr_addr0  input  ADDR_W  write port 0 index
wr_data0  input  DATA_W  write port 0 data
wr_en1  input  1  write port 1 enable
wr_addr1  input  ADDR_W  write port 1 index
wr_data1  input  DATA_W  write port 1 data

Behaviour:
- Reset (rst_n=0, asynchronous, no clock needed): all 32 registers = 0; rd_data0 = rd_data1 = 0. Held while rst_n low. Writes and reads ignored during reset.
- First active edge after rst_n rises behaves normally; no synchronizer inside.
- Read latency: 1 cycle.
  - On a rising edge with rd_enN=1: rd_dataN <= regs[rd_addrN], the value before this edge's writes (read-before-write).
  - With rd_enN=0: rd_dataN holds its previous value.
- Write: on a rising edge with wr_enN=1, regs[wr_addrN] <= wr_dataN. Visible on a read sampled at the next edge or later.
- Both write ports to the same index in the same cycle: port 1 wins. Different indices: both written.
- Both read ports may address the same or any register simultaneously; no restriction.
- Register 0 is an ordinary writable/readable register. No hard-wired zero; the RA=0 literal-zero rule is handled by the datapath.
- Read of an address being written on the same edge returns the old value. The pipeline forwards the new value externally.
- No X propagation: all storage initialized by reset.
- Widths exact: addresses are full ADDR_W, all 32 entries reachable, no wrap or aliasing.

Test Plan:
- Reset: rst_n=0 mid-run after writes; check rd_data0/1 = 0 immediately (async). After release, reading r0..r31 returns 0.
- Write/read latency: write r5=0x0123456789ABCDEF via port 0; next edge rd_en0=1, addr 5 -> rd_data0 = 0x0123456789ABCDEF one edge later.
- Same-edge read/write: r7=0x11; at one edge write r7=0x22 and read r7 on port 1 -> rd_data1 = 0x11; the following read -> 0x22.
- Dual write conflict: wr_en0=wr_en1=1, both addr 3, data 0xAAAA and 0xBBBB -> subsequent read of r3 = 0xBBBB. Repeat with addrs 3 and 4 -> r3=0xAAAA, r4=0xBBBB.
- Read enable hold: rd_data0 shows r9=0x55; drop rd_en0, change rd_addr0 to r10=0x66 -> rd_data0 stays 0x55 until rd_en0 is reasserted.
- Full sweep: write r_i = i*0x0101010101010101 for i=0..31 via alternating ports. Read all 32 on both ports -> exact values, r0 = 0, r31 = 0x1F1F1F1F1F1F1F1F.

Source files
------------

// File: rtl/regs_file.sv
// regs_file: 32 x 64-bit general-purpose register file, two registered read
// ports and two write ports. The file itself does not forward writes to reads:
// a read returns the value held before the same edge's writes.
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   rd_enN, rd_addrN     read port N request (N = 0,1)
//   rd_dataN             read port N data, valid one edge after the request,
//                        held while rd_enN is low
//   wr_enN, wr_addrN,    write port N (N = 0,1); port 1 wins when both
//   wr_dataN             ports target the same index on the same edge
//
// Data words use [0:DATA_W-1] ordering (bit 0 is the MSB).

module regs_file_rdport #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              en_i,
    input  logic [ADDR_W-1:0]                 addr_i,
    input  logic [NREGS-1:0][0:DATA_W-1]      regs_i,
    output logic [0:DATA_W-1]                 data_o
);
    logic [0:DATA_W-1] data_q;

    // regs_i is the registered array, so this samples pre-write contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    data_q <= '0;
        else if (en_i) data_q <= regs_i[addr_i];
    end

    assign data_o = data_q;
endmodule

module regs_file #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en0,
    input  logic [ADDR_W-1:0] rd_addr0,
    output logic [0:DATA_W-1] rd_data0,
    input  logic              rd_en1,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [0:DATA_W-1] rd_data1,
    input  logic              wr_en0,
    input  logic [ADDR_W-1:0] wr_addr0,
    input  logic [0:DATA_W-1] wr_data0,
    input  logic              wr_en1,
    input  logic [ADDR_W-1:0] wr_addr1,
    input  logic [0:DATA_W-1] wr_data1
);
    localparam int NRD = 2;

    logic [NREGS-1:0][0:DATA_W-1] regs_q, regs_d;

    logic [NRD-1:0]                rd_en;
    logic [NRD-1:0][ADDR_W-1:0]    rd_addr;
    logic [NRD-1:0][0:DATA_W-1]    rd_data;

    assign rd_en    = {rd_en1, rd_en0};
    assign rd_addr  = {rd_addr1, rd_addr0};
    assign rd_data0 = rd_data[0];
    assign rd_data1 = rd_data[1];

    // Port 1 is applied last so it takes priority on an index collision.
    always_comb begin
        regs_d = regs_q;
        if (wr_en0) regs_d[wr_addr0] = wr_data0;
        if (wr_en1) regs_d[wr_addr1] = wr_data1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) regs_q <= '0;
        else        regs_q <= regs_d;
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        regs_file_rdport #(
            .DATA_W(DATA_W),
            .ADDR_W(ADDR_W),
            .NREGS (NREGS)
        ) u_rdport (
            .clk   (clk),
            .rst_n (rst_n),
            .en_i  (rd_en[p]),
            .addr_i(rd_addr[p]),
            .regs_i(regs_q),
            .data_o(rd_data[p])
        );
    end
endmodule

// File: tb/tb_regs_file.sv
module tb_regs_file;
    logic        clk, rst_n;
    logic        rd_en0, rd_en1, wr_en0, wr_en1;
    logic [4:0]  rd_addr0, rd_addr1, wr_addr0, wr_addr1;
    logic [0:63] rd_data0, rd_data1, wr_data0, wr_data1;

    regs_file dut (
        .clk(clk), .rst_n(rst_n),
        .rd_en0(rd_en0), .rd_addr0(rd_addr0), .rd_data0(rd_data0),
        .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_data1(rd_data1),
        .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
        .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model and scoreboard: expected read data is pushed when the
    // request is driven, observed data is pushed after the edge.
    logic [0:63] model [32];
    logic [0:63] last0, last1;
    logic [0:63] exp0[$], exp1[$], obs0[$], obs1[$];

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = '0;
        last0 = '0; last1 = '0;
        exp0.delete(); exp1.delete(); obs0.delete(); obs1.delete();
    endtask

    task automatic step(input bit re0, input int ra0, input bit re1, input int ra1,
                        input bit we0, input int wa0, input logic [0:63] wd0,
                        input bit we1, input int wa1, input logic [0:63] wd1);
        rd_en0 = re0; rd_addr0 = ra0[4:0];
        rd_en1 = re1; rd_addr1 = ra1[4:0];
        wr_en0 = we0; wr_addr0 = wa0[4:0]; wr_data0 = wd0;
        wr_en1 = we1; wr_addr1 = wa1[4:0]; wr_data1 = wd1;
        // reads see pre-edge contents; writes land afterwards, port 1 last
        if (re0) last0 = model[ra0];
        if (re1) last1 = model[ra1];
        exp0.push_back(last0);
        exp1.push_back(last1);
        if (we0) model[wa0] = wd0;
        if (we1) model[wa1] = wd1;
        @(posedge clk); #1;
        obs0.push_back(rd_data0);
        obs1.push_back(rd_data1);
        rd_en0 = 0; rd_en1 = 0; wr_en0 = 0; wr_en1 = 0;
    endtask

    task automatic wr(input int a, input logic [0:63] d);
        step(0, 0, 0, 0, 1, a, d, 0, 0, '0);
    endtask

    task automatic test_reset();
        rst_n = 0;
        rd_en0 = 0; rd_en1 = 0; wr_en0 = 0; wr_en1 = 0;
        rd_addr0 = 0; rd_addr1 = 0; wr_addr0 = 0; wr_addr1 = 0;
        wr_data0 = '0; wr_data1 = '0;
        model_clear();
        #2;
        tests++;
        if (rd_data0 !== 64'h0 || rd_data1 !== 64'h0) begin
            fails++;
            $display("FAIL reset_initial: got %h/%h expected 0/0", rd_data0, rd_data1);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_latency();
        wr(5, 64'h0123456789ABCDEF);
        step(1, 5, 0, 0, 0, 0, '0, 0, 0, '0);
        tests++;
        if (rd_data0 !== 64'h0123456789ABCDEF) begin
            fails++;
            $display("FAIL latency_const: got %h expected 0123456789abcdef", rd_data0);
        end
        while (exp0.size() > 0) begin
            logic [0:63] e0, o0, e1, o1;
            e0 = exp0.pop_front(); o0 = obs0.pop_front();
            e1 = exp1.pop_front(); o1 = obs1.pop_front();
            tests += 2;
            if (o0 !== e0) begin fails++; $display("FAIL latency p0: got %h expected %h", o0, e0); end
            if (o1 !== e1) begin fails++; $display("FAIL latency p1: got %h expected %h", o1, e1); end
        end
    endtask

    task automatic test_same_edge();
        wr(7, 64'h11);
        step(0, 0, 1, 7, 1, 7, 64'h22, 0, 0, '0);
        tests++;
        if (rd_data1 !== 64'h11) begin
            fails++;
            $display("FAIL same_edge_old: got %h expected 11", rd_data1);
        end
        step(0, 0, 1, 7, 0, 0, '0, 0, 0, '0);
        step(1, 7, 1, 7, 0, 0, '0, 0, 0, '0);
        while (exp0.size() > 0) begin
            logic [0:63] e0, o0, e1, o1;
            e0 = exp0.pop_front(); o0 = obs0.pop_front();
            e1 = exp1.pop_front(); o1 = obs1.pop_front();
            tests += 2;
            if (o0 !== e0) begin fails++; $display("FAIL same_edge p0: got %h expected %h", o0, e0); end
            if (o1 !== e1) begin fails++; $display("FAIL same_edge p1: got %h expected %h", o1, e1); end
        end
    endtask

    task automatic test_dual_write();
        step(0, 0, 0, 0, 1, 3, 64'hAAAA, 1, 3, 64'hBBBB);
        step(1, 3, 1, 3, 0, 0, '0, 0, 0, '0);
        tests++;
        if (rd_data0 !== 64'hBBBB) begin
            fails++;
            $display("FAIL dual_write_same: got %h expected bbbb", rd_data0);
        end
        step(0, 0, 0, 0, 1, 3, 64'hAAAA, 1, 4, 64'hBBBB);
        step(1, 3, 1, 4, 0, 0, '0, 0, 0, '0);
        step(1, 4, 1, 3, 1, 4, 64'h1234, 1, 4, 64'h5678);
        step(1, 4, 1, 4, 0, 0, '0, 0, 0, '0);
        while (exp0.size() > 0) begin
            logic [0:63] e0, o0, e1, o1;
            e0 = exp0.pop_front(); o0 = obs0.pop_front();
            e1 = exp1.pop_front(); o1 = obs1.pop_front();
            tests += 2;
            if (o0 !== e0) begin fails++; $display("FAIL dual_write p0: got %h expected %h", o0, e0); end
            if (o1 !== e1) begin fails++; $display("FAIL dual_write p1: got %h expected %h", o1, e1); end
        end
    endtask

    task automatic test_rd_hold();
        step(0, 0, 0, 0, 1, 9, 64'h55, 1, 10, 64'h66);
        step(1, 9, 1, 10, 0, 0, '0, 0, 0, '0);
        step(0, 10, 0, 9, 0, 0, '0, 0, 0, '0);
        step(0, 10, 0, 9, 1, 9, 64'h77, 0, 0, '0);
        tests++;
        if (rd_data0 !== 64'h55) begin
            fails++;
            $display("FAIL rd_hold_const: got %h expected 55", rd_data0);
        end
        step(1, 10, 0, 0, 0, 0, '0, 0, 0, '0);
        step(0, 0, 1, 9, 0, 0, '0, 0, 0, '0);
        while (exp0.size() > 0) begin
            logic [0:63] e0, o0, e1, o1;
            e0 = exp0.pop_front(); o0 = obs0.pop_front();
            e1 = exp1.pop_front(); o1 = obs1.pop_front();
            tests += 2;
            if (o0 !== e0) begin fails++; $display("FAIL rd_hold p0: got %h expected %h", o0, e0); end
            if (o1 !== e1) begin fails++; $display("FAIL rd_hold p1: got %h expected %h", o1, e1); end
        end
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 32; i++) begin
            logic [0:63] v;
            v = 64'(i) * 64'h0101010101010101;
            if (i % 2 == 0) step(0, 0, 0, 0, 1, i, v, 0, 0, '0);
            else            step(0, 0, 0, 0, 0, 0, '0, 1, i, v);
        end
        for (int i = 0; i < 32; i++) step(1, i, 1, 31 - i, 0, 0, '0, 0, 0, '0);
        tests++;
        if (rd_data0 !== 64'h1F1F1F1F1F1F1F1F || rd_data1 !== 64'h0) begin
            fails++;
            $display("FAIL sweep_ends: got %h/%h expected 1f1f1f1f1f1f1f1f/0", rd_data0, rd_data1);
        end
        while (exp0.size() > 0) begin
            logic [0:63] e0, o0, e1, o1;
            e0 = exp0.pop_front(); o0 = obs0.pop_front();
            e1 = exp1.pop_front(); o1 = obs1.pop_front();
            tests += 2;
            if (o0 !== e0) begin fails++; $display("FAIL sweep p0: got %h expected %h", o0, e0); end
            if (o1 !== e1) begin fails++; $display("FAIL sweep p1: got %h expected %h", o1, e1); end
        end
    endtask

    task automatic test_reset_midrun();
        // ports hold nonzero data from the sweep; reset must clear them at once
        step(1, 31, 1, 17, 0, 0, '0, 0, 0, '0);
        exp0.delete(); exp1.delete(); obs0.delete(); obs1.delete();
        rst_n = 0;
        #1;
        tests++;
        if (rd_data0 !== 64'h0 || rd_data1 !== 64'h0) begin
            fails++;
            $display("FAIL reset_async: got %h/%h expected 0/0", rd_data0, rd_data1);
        end
        // activity while in reset must be ignored
        wr_en0 = 1; wr_addr0 = 5'd1; wr_data0 = 64'hFF;
        wr_en1 = 1; wr_addr1 = 5'd2; wr_data1 = 64'hEE;
        rd_en0 = 1; rd_addr0 = 5'd1;
        @(posedge clk); #1;
        wr_en0 = 0; wr_en1 = 0; rd_en0 = 0;
        model_clear();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 32; i++) step(1, i, 1, 31 - i, 0, 0, '0, 0, 0, '0);
        while (exp0.size() > 0) begin
            logic [0:63] e0, o0, e1, o1;
            e0 = exp0.pop_front(); o0 = obs0.pop_front();
            e1 = exp1.pop_front(); o1 = obs1.pop_front();
            tests += 2;
            if (o0 !== e0) begin fails++; $display("FAIL reset_clear p0: got %h expected %h", o0, e0); end
            if (o1 !== e1) begin fails++; $display("FAIL reset_clear p1: got %h expected %h", o1, e1); end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_same_edge();
        test_dual_write();
        test_rd_hold();
        test_sweep();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
